// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module : fetch_stage_pkg
//  Brief  : Shared types, constants and helpers for the instruction-fetch stage
//  Rev    : 1.0  initial release
// ============================================================================
package fetch_stage_pkg;

  // Fetch control states
  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,  // free to issue a read
    ST_WAIT  = 3'd1,  // read outstanding
    ST_HOLD  = 3'd2,  // returned word parked while decode stalls
    ST_DROP  = 3'd3,  // outstanding read belongs to a squashed path
    ST_HALT  = 3'd4   // stopped on a HALT instruction
  } fetch_state_t;

  localparam logic [15:0] DEFAULT_NOP     = 16'h0800;
  localparam logic [4:0]  DEFAULT_HALT_OP = 5'b00000;

  // Sequential PC step; 16-bit wrap is intentional
  function automatic logic [15:0] pc_step(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`default_nettype none
// ============================================================================
//  Module : fetch_hold_buf
//  Brief  : One-entry instruction buffer (16-bit word + full flag) that keeps
//           a returned word while decode is stalled
//  Rev    : 1.0  initial release
// ============================================================================
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [15:0] data_in,
  output logic [15:0] data,
  output logic        full
);

  // Clear beats load so a redirect always empties the buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= 16'h0000;
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      data <= data_in;
      full <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module : fetch_stage
//  Brief  : Instruction-fetch stage: owns the PC, talks to a multi-cycle
//           instruction memory, feeds F/D and drives the 3-stage flush chain
//  Rev    : 1.0  initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = DEFAULT_NOP,
  parameter logic [4:0]  HALT_OP   = DEFAULT_HALT_OP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        imem_stall,
  output logic [15:0] instr,
  output logic [15:0] pc_inc,
  output logic        valid,
  output logic        flush,
  output logic        flush_again,
  output logic        flush_final,
  output logic        halted
);

  fetch_state_t state, next_state;
  logic [15:0]  pc, next_pc;
  logic [15:0]  deliver_data;
  logic [15:0]  hold_data;
  logic         hold_full;
  logic         issue, deliver, hb_load, hb_clear;

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (hb_load),
    .clear   (hb_clear),
    .data_in (imem_data),
    .data    (hold_data),
    .full    (hold_full)
  );

  assign issue = (state == ST_FETCH) & ~stall & ~imem_stall & ~redirect;

  // Next-state, next-PC and delivery decision; redirect overrides everything
  always_comb begin
    next_state   = state;
    next_pc      = pc;
    deliver      = 1'b0;
    deliver_data = hold_data;
    hb_load      = 1'b0;
    hb_clear     = 1'b0;
    if (redirect) begin
      next_pc  = redirect_pc;
      hb_clear = 1'b1;
      // A read still in flight must be absorbed before issuing on the new path
      next_state = (((state == ST_WAIT) || (state == ST_DROP)) && !imem_done)
                   ? ST_DROP : ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          if (issue) begin
            if (imem_done) begin
              deliver      = 1'b1;
              deliver_data = imem_data;
            end else begin
              next_state = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (imem_done) begin
            if (stall) begin
              hb_load    = 1'b1;
              next_state = ST_HOLD;
            end else begin
              deliver      = 1'b1;
              deliver_data = imem_data;
            end
          end
        end
        ST_HOLD: begin
          if (!stall && hold_full) begin
            deliver  = 1'b1;
            hb_clear = 1'b1;
          end
        end
        ST_DROP: begin
          if (imem_done) next_state = ST_FETCH;
        end
        ST_HALT: begin
          next_state = ST_HALT;
        end
        default: next_state = ST_FETCH;
      endcase
      if (deliver) begin
        next_pc    = pc_step(pc);
        next_state = (deliver_data[15:11] == HALT_OP) ? ST_HALT : ST_FETCH;
      end
    end
  end

  // State, PC and the registered tail of the flush chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      flush_again <= 1'b0;
      flush_final <= 1'b0;
    end else begin
      state       <= next_state;
      pc          <= next_pc;
      flush_again <= redirect;
      flush_final <= flush_again;
    end
  end

  // Outputs are forced quiet while reset is held, independent of the clock
  assign imem_rd   = issue & ~rst;
  assign imem_addr = pc;
  assign valid     = deliver & ~rst;
  assign instr     = valid ? deliver_data : NOP_INSTR;
  assign pc_inc    = pc_step(pc);
  assign flush     = redirect & ~rst;
  assign halted    = (state == ST_HALT);

endmodule
`default_nettype wire
